// File: rtl/rf_scan_reader.sv
// Register-file scan reader: sweeps rf_read_addr from a captured first address
// to a captured last address (wrapping modulo 2^ADDR_W) and emits each sampled
// word on a valid/ready stream tagged with its address.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request a scan (sampled in IDLE only)
//   first_addr        first register to read, captured on accepted start
//   last_addr         last register to read, captured on accepted start
//   abort             terminate an active scan, no done
//   rf_read_addr      address to the register file's combinational read port
//   rf_read_data      combinational read data from the register file
//   out_valid/ready   stream handshake
//   out_addr/out_data register index and contents of the current word
//   busy              high whenever the reader is not idle
//   done              one-cycle pulse after the last word is accepted
module rf_scan_reader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] out_addr_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d;
  logic              done_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      last_q    <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      out_addr  <= out_addr_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      done      <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    out_addr_d  = out_addr;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // start takes priority over abort; abort means nothing when idle
        if (start) begin
          ptr_d   = first_addr;
          last_d  = last_addr;
          state_d = READ;
        end
      end

      READ: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          // word is a snapshot of the register file at this edge
          out_data_d  = rf_read_data;
          out_addr_d  = ptr_q;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
      end

      SEND: begin
        // abort wins over a same-cycle handshake; the word is dropped
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (ptr_q == last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // The pointer only moves on a handshake, so no new read is issued in SEND.
  assign rf_read_addr = ptr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_rf_scan_reader.sv
// Self-checking bench for rf_scan_reader: a register-file model, a
// transaction-level reference model checked every cycle, directed scenarios
// with literal expectations, and a randomized phase.
module tb_rf_scan_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int          N  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic          abort = 1'b0;
  logic [AW-1:0] rf_read_addr;
  logic [DW-1:0] rf_read_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  rf_scan_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .first_addr  (first_addr),
    .last_addr   (last_addr),
    .abort       (abort),
    .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, writes happen on negedge.
  logic [DW-1:0] regs [N];
  assign rf_read_data = regs[rf_read_addr];

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state: expected remaining addresses of the current scan.
  bit            m_busy = 1'b0;
  int            exp_q[$];
  logic [DW-1:0] exp_d = '0;
  int            obs[$];
  int            hs_cnt = 0;
  int            done_cnt = 0;
  bit            pv = 1'b0;
  logic [AW-1:0] pa = '0;
  logic [DW-1:0] pd = '0;

  // Compare process: sample 1 time unit after each posedge. Inputs visible now
  // are those that were applied at that edge; pv/pa/pd hold pre-edge outputs.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_busy = 1'b0;
        exp_q.delete();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_rd_addr", 32'(rf_read_addr), 32'd0);
        pv = 1'b0;
      end else begin
        if (m_busy) begin
          if (abort) begin
            m_busy = 1'b0;
            exp_q.delete();
            check("abort_valid", 32'(out_valid), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
          end else if (pv && out_ready) begin
            check("hs_addr", 32'(pa), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hFFFF_FFFF);
            check("hs_data", pd, exp_d);
            obs.push_back(int'(pa));
            hs_cnt++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            check("hs_valid_drop", 32'(out_valid), 32'd0);
            if (exp_q.size() == 0) begin
              m_busy = 1'b0;
              done_cnt++;
              check("done_pulse", 32'(done), 32'd1);
              check("done_busy", 32'(busy), 32'd0);
            end else begin
              check("next_busy", 32'(busy), 32'd1);
              check("next_done", 32'(done), 32'd0);
              check("next_rd_addr", 32'(rf_read_addr), 32'(exp_q[0]));
            end
          end else if (pv) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_addr", 32'(out_addr), 32'(pa));
            check("hold_data", out_data, pd);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_done", 32'(done), 32'd0);
          end else begin
            // one dead cycle after start/handshake, then the next word appears
            exp_d = regs[exp_q[0]];
            check("word_valid", 32'(out_valid), 32'd1);
            check("word_addr", 32'(out_addr), 32'(exp_q[0]));
            check("word_data", out_data, exp_d);
            check("word_busy", 32'(busy), 32'd1);
            check("word_done", 32'(done), 32'd0);
          end
        end else begin
          if (start) begin
            int a;
            a = int'(first_addr);
            exp_q.push_back(a);
            while (a != int'(last_addr)) begin
              a = (a + 1) % N;
              exp_q.push_back(a);
            end
            m_busy = 1'b1;
            check("start_busy", 32'(busy), 32'd1);
            check("start_valid", 32'(out_valid), 32'd0);
            check("start_rd_addr", 32'(rf_read_addr), 32'(first_addr));
          end else begin
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_valid", 32'(out_valid), 32'd0);
          end
          check("idle_done", 32'(done), 32'd0);
        end
        pv = out_valid;
        pa = out_addr;
        pd = out_data;
      end
    end
  end

  // Register-file write requests executed by step() at the negedge.
  bit            rand_wr = 1'b0;
  bit            wr_pend = 1'b0;
  int            wr_a = 0;
  logic [DW-1:0] wr_d = '0;

  task automatic step();
    @(negedge clk);
    if (rand_wr && ($urandom_range(0, 3) == 0)) regs[$urandom_range(1, N - 1)] = $urandom;
    if (wr_pend) begin
      regs[wr_a] = wr_d;
      wr_pend = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic begin_scan(input int f, input int l);
    first_addr = AW'(f);
    last_addr  = AW'(l);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (m_busy && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(m_busy), 32'd0);
  endtask

  task automatic wait_word(input int addr, input int budget, input string name);
    int n = 0;
    while (!(out_valid && int'(out_addr) == addr) && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(out_addr), 32'(addr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    int e2 [4];
    logic [DW-1:0] d;
    e2 = '{30, 31, 0, 1};
    for (int i = 0; i < N; i++) regs[i] = 32'(i * 4);

    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Full-file sweep, ready always high.
    out_ready = 1'b1;
    begin_scan(0, 31);
    for (int k = 0; k < N; k++) begin
      step();
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_addr", 32'(out_addr), 32'(k));
      check("t1_data", out_data, 32'(k * 4));
      step();
    end
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    step();
    check("t1_done_once", 32'(done), 32'd0);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // Wrapping range.
    h0 = hs_cnt;
    obs.delete();
    begin_scan(30, 1);
    wait_idle(100, "t2_timeout");
    check("t2_hs", 32'(hs_cnt - h0), 32'd4);
    check("t2_size", 32'(obs.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs.size(); i++) check("t2_seq", 32'(obs[i]), 32'(e2[i]));

    // Backpressure on word 3.
    begin_scan(0, 5);
    wait_word(3, 50, "t3_reach");
    out_ready = 1'b0;
    d = out_data;
    repeat (5) begin
      step();
      check("t3_valid", 32'(out_valid), 32'd1);
      check("t3_addr", 32'(out_addr), 32'd3);
      check("t3_data", out_data, 32'd12);
      check("t3_data_stable", out_data, d);
      check("t3_rd_addr", 32'(rf_read_addr), 32'd3);
    end
    out_ready = 1'b1;
    wait_idle(50, "t3_timeout");

    // Register write between scan words.
    begin_scan(5, 6);
    step();
    check("t4_w5_addr", 32'(out_addr), 32'd5);
    check("t4_w5_data", out_data, 32'd20);
    step();
    wr_a = 6;
    wr_d = 32'hDEAD_BEEF;
    wr_pend = 1'b1;
    step();
    check("t4_w6_addr", 32'(out_addr), 32'd6);
    check("t4_w6_data", out_data, 32'hDEAD_BEEF);
    wait_idle(20, "t4_timeout");

    // Abort together with a handshake on word 2.
    h0 = done_cnt;
    begin_scan(0, 7);
    wait_word(2, 50, "t5_reach");
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    step();
    check("t5_no_done", 32'(done_cnt - h0), 32'd0);
    h0 = hs_cnt;
    obs.delete();
    begin_scan(4, 4);
    wait_idle(20, "t5b_timeout");
    check("t5b_hs", 32'(hs_cnt - h0), 32'd1);
    check("t5b_addr", (obs.size() > 0) ? 32'(obs[0]) : 32'hFFFF_FFFF, 32'd4);

    // Asynchronous reset while a word is stalled in SEND.
    out_ready = 1'b0;
    begin_scan(0, 31);
    wait_word(0, 20, "t6_reach");
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    obs.delete();
    begin_scan(2, 3);
    wait_idle(20, "t6b_timeout");
    check("t6b_size", 32'(obs.size()), 32'd2);
    if (obs.size() == 2) begin
      check("t6b_a0", 32'(obs[0]), 32'd2);
      check("t6b_a1", 32'(obs[1]), 32'd3);
    end

    // Randomized scans: random ranges, backpressure, aborts, ignored starts,
    // and concurrent register writes.
    rand_wr = 1'b1;
    for (int s = 0; s < 40; s++) begin
      int n;
      out_ready = ($urandom_range(0, 9) < 7);
      abort = ($urandom_range(0, 3) == 0);
      begin_scan(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)));
      abort = 1'b0;
      n = 0;
      while (m_busy && n < 400) begin
        out_ready  = ($urandom_range(0, 9) < 7);
        abort      = ($urandom_range(0, 59) == 0);
        start      = ($urandom_range(0, 7) == 0);
        first_addr = AW'($urandom);
        last_addr  = AW'($urandom);
        step();
        n++;
      end
      start = 1'b0;
      abort = ($urandom_range(0, 1) == 0);
      check("rand_timeout", 32'(m_busy), 32'd0);
      step();
      abort = 1'b0;
    end
    rand_wr = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_scan_reader.md
Name: rf_scan_reader

Overview:
- Debug/trace reader for the CPU register file: drives the register file's combinational read port to sweep an address range.
- Each sampled word leaves on a valid/ready stream, tagged with its address.
- Sits beside the datapath and uses one spare read port, so normal operation is never stalled.
- Used for post-run register dumps and for checkpoint comparison in the testbench and debug UART path.

Parameters:
- DATA_W, 32, width of a register word.
- ADDR_W, 5, register address width; range is 0..2^ADDR_W-1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a scan; sampled in IDLE only.
- first_addr  input  ADDR_W  first register to read; captured on accepted start.
- last_addr  input  ADDR_W  last register to read; captured on accepted start.
- abort  input  1  terminate the scan; return to IDLE.
- rf_read_addr  output  ADDR_W  address to the register file read port.
- rf_read_data  input  DATA_W  combinational read data from the register file.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream accepts word.
- out_addr  output  ADDR_W  register index of the current word.
- out_data  output  DATA_W  register contents.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ptr, last_q, rf_read_addr, out_addr, out_data = 0; out_valid, busy, done = 0. Reset mid-scan discards everything immediately; no done.
- IDLE:
  - start=1 at posedge: ptr<=first_addr, last_q<=last_addr; go to READ.
  - start while busy is ignored; first_addr/last_addr changes during a scan have no effect.
- READ:
  - rf_read_addr=ptr for the whole cycle.
  - At the next posedge: out_data<=rf_read_data, out_addr<=ptr, out_valid<=1; go to SEND.
  - The register file writes on negedge, so posedge sampling sees any write from the preceding half-cycle. Each word is a snapshot taken at its own READ cycle, not an atomic whole-file snapshot.
- SEND:
  - out_valid=1; out_addr and out_data hold stable until the handshake (out_valid & out_ready at posedge).
  - On handshake with ptr==last_q: out_valid<=0, done<=1 for one cycle, go to IDLE.
  - On handshake otherwise: ptr<=ptr+1 modulo 2^ADDR_W, out_valid<=0, go to READ.
  - No handshake: stay in SEND.
- Throughput: at most one word per 2 cycles. Latency from start to the first out_valid is 2 posedges.
- Range and wrap:
  - first_addr==last_addr: exactly one word.
  - first_addr>last_addr: wraps through 2^ADDR_W-1 to 0. Example: 30..1 yields 30, 31, 0, 1.
  - A full file is first=0, last=31, giving 32 words.
- Register 0 is read like any other address; it reads 0 from the register file and no special-casing is done here.
- abort=1 at posedge in READ or SEND: out_valid<=0, go to IDLE, no done.
  - abort beats a same-cycle handshake; that word counts as not delivered.
  - abort in IDLE is ignored. If abort and start are both high in IDLE, start wins.
- busy is combinational from state. done is registered and never coincides with out_valid.

Test Plan:
- Reset, then start with first=0, last=31, out_ready=1, register file preloaded with reg[i]=i*4 (reg0=0) -> 32 words with out_addr 0..31 and out_data=i*4; word k valid at cycle 2+2k after start; done pulses once, one cycle after the handshake on addr 31; busy drops the same cycle.
- Wrap range first=30, last=1 -> out_addr sequence 30, 31, 0, 1, then done; exactly 4 handshakes.
- Backpressure: hold out_ready=0 for 5 cycles on word 3 -> out_valid stays 1, out_addr=3 and out_data unchanged throughout; no further read is issued until the handshake.
- Write during scan: scan 5..6; at the negedge before the READ of addr 6, write reg6=0xDEADBEEF -> word 6 carries 0xDEADBEEF, and word 5 keeps its old value.
- abort asserted in SEND together with out_ready=1 on word 2 of 0..7 -> out_valid low next cycle, state IDLE, no done; a following start with 4..4 yields a single word addr 4.
- rst_n pulled low asynchronously mid-SEND -> out_valid, busy and done go 0 immediately without a clock edge; after release, start behaves normally.
